// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS execute stage: ALU control codes, the
// mult/div/HI-LO funct field values and the mult/div engine state type.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam int MD_ITER_DEF = 32;

  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

  // MULT/MULTU/DIV/DIVU share the prefix 0110; the low two bits pick the op.
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == F_MULT[5:2];
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Iterative multiply/divide engine with HI/LO registers.
// One shift-add (mult) or restoring-subtract (div) step per clock over
// MD_ITER cycles, operating on magnitudes; the sign fix is applied when the
// final step is written into HI/LO.
module muldiv_engine
  import mips_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy
);

  localparam int CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  md_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_lo;
  logic                 r_neg_hi;
  logic                 r_div0;
  logic [WIDTH-1:0]     r_a_raw;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_acc;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_step;

  function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Operand magnitudes; op bit 0 set means the unsigned variant.
  assign w_a_neg = ~i_op[0] & i_src_a[WIDTH-1];
  assign w_b_neg = ~i_op[0] & i_src_b[WIDTH-1];
  assign w_a_mag = neg_w(w_a_neg, i_src_a);
  assign w_b_mag = neg_w(w_b_neg, i_src_b);

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; shift left, trial subtract, restore on borrow.
  assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_step = r_is_div ? w_div_next : w_mul_next;

  // Engine FSM: accept in IDLE, iterate in RUN, sign-fix into HI/LO on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state  <= MD_RUN;
            r_cnt    <= '0;
            r_is_div <= i_op[1];
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_div0   <= i_op[1] & (i_src_b == '0);
            r_a_raw  <= i_src_a;
            r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
            r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
          end else begin
            if (i_mthi) r_hi <= i_src_a;
            if (i_mtlo) r_lo <= i_src_a;
          end
        end
        MD_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            if (r_div0) begin
              r_hi <= r_a_raw;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_lo <= neg_w(r_neg_lo, w_step[WIDTH-1:0]);
              r_hi <= neg_w(r_neg_hi, w_step[2*WIDTH-1:WIDTH]);
            end else begin
              {r_hi, r_lo} <= neg_d(r_neg_lo, w_step);
            end
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state == MD_RUN);

endmodule

// File: rtl/alu_muldiv.sv
// MIPS execute stage: combinational ALU, HI/LO result mux, zero flag, stall
// generation, plus the iterative mult/div engine (muldiv_engine).
// Optional feature macro: ALU_OVERFLOW_EN enables the signed add/sub
// overflow flag; when undefined the overflow output is tied low.
module alu_muldiv
  import mips_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = MD_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ALUCtrl,
  input  logic [5:0]       funct,
  input  logic             rtype,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             stall
);

  logic                    w_md;
  logic                    w_mfhi;
  logic                    w_mflo;
  logic                    w_mthi;
  logic                    w_mtlo;
  logic                    w_busy;
  logic                    w_sub;
  logic [WIDTH-1:0]        w_b_eff;
  logic [WIDTH-1:0]        w_sum;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_alu;
  logic [WIDTH-1:0]        w_hi;
  logic [WIDTH-1:0]        w_lo;

  assign w_md   = rtype & is_muldiv(funct);
  assign w_mfhi = rtype & (funct == F_MFHI);
  assign w_mflo = rtype & (funct == F_MFLO);
  assign w_mthi = rtype & (funct == F_MTHI);
  assign w_mtlo = rtype & (funct == F_MTLO);

  // Shared adder: SUB is A + ~B + 1.
  assign w_sub   = (ALUCtrl == ALU_SUB);
  assign w_b_eff = w_sub ? ~src_b : src_b;
  assign w_sum   = src_a + w_b_eff + WIDTH'(w_sub);
  assign w_a_s   = src_a;
  assign w_b_s   = src_b;

  // ALU operation select; unknown codes produce zero.
  always_comb begin
    w_alu = '0;
    case (ALUCtrl)
      ALU_AND: w_alu = src_a & src_b;
      ALU_OR:  w_alu = src_a | src_b;
      ALU_ADD: w_alu = w_sum;
      ALU_SUB: w_alu = w_sum;
      ALU_SLT: w_alu = WIDTH'(w_a_s < w_b_s);
      ALU_NOR: w_alu = ~(src_a | src_b);
      default: w_alu = '0;
    endcase
  end

  // Final result: HI/LO reads override the ALU output.
  always_comb begin
    result = w_alu;
    if (w_mfhi)      result = w_hi;
    else if (w_mflo) result = w_lo;
  end

  assign zero = (result == '0);

`ifdef ALU_OVERFLOW_EN
  assign overflow = ((ALUCtrl == ALU_ADD) | w_sub) &
                    (src_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                    (w_sum[WIDTH-1] != src_a[WIDTH-1]);
`else
  assign overflow = 1'b0;
`endif

  assign busy  = w_busy;
  assign stall = w_busy & (w_md | w_mfhi | w_mflo | w_mthi | w_mtlo);

  muldiv_engine #(
    .WIDTH   (WIDTH),
    .MD_ITER (MD_ITER)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_md & ~w_busy),
    .i_op    (funct[1:0]),
    .i_mthi  (w_mthi & ~w_busy),
    .i_mtlo  (w_mtlo & ~w_busy),
    .i_src_a (src_a),
    .i_src_b (src_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_busy)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: table-driven ALU vectors plus
// hand-written mult/div, stall, back-to-back and reset sequences.
module tb_alu_muldiv;
  import mips_alu_pkg::*;

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  ALUCtrl;
  logic [5:0]  funct;
  logic        rtype;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;
  logic        stall;

  int n_vec;
  int n_err;

  alu_muldiv #(.WIDTH(32), .MD_ITER(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ALUCtrl  (ALUCtrl),
    .funct    (funct),
    .rtype    (rtype),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .busy     (busy),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [5:0]  fn;
    logic        rt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    rtype   = 1'b0;
    funct   = 6'b000000;
    ALUCtrl = ALU_AND;
    src_a   = '0;
    src_b   = '0;
  endtask

  // Present a mult/div for one accept edge, then drop it.
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    rtype = 1'b1;
    funct = fn;
    src_a = a;
    src_b = b;
    tick();
    nop();
  endtask

  // Count busy cycles (bounded) and expect exactly 32.
  task automatic wait_done(input string name);
    int c;
    c = 0;
    #1;
    while (busy && c < 100) begin
      c++;
      tick();
    end
    chk(name, 64'(c), 64'd32);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rtype = 1'b1;
    funct = F_MFLO;
    #1;
    chk({name, "_lo"}, {32'd0, result}, {32'd0, exp_lo});
    funct = F_MFHI;
    #1;
    chk({name, "_hi"}, {32'd0, result}, {32'd0, exp_hi});
    nop();
  endtask

  initial begin
    int c;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{ALU_AND, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[1]  = '{ALU_OR,  6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[2]  = '{ALU_ADD, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{ALU_SUB, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 1'b0};
    vecs[4]  = '{ALU_SLT, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0};
    vecs[5]  = '{ALU_NOR, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{ALU_ADD, 6'd0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, OVF_EN};
    vecs[7]  = '{ALU_SUB, 6'd0, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, OVF_EN};
    vecs[8]  = '{ALU_AND, 6'd0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[9]  = '{4'b0011, 6'd0, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{ALU_OR,  F_MFHI, 1'b0, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0};
    vecs[11] = '{ALU_ADD, 6'b100000, 1'b1, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{ALU_SLT, 6'd0, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};

    // Reset state
    nop();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_busy_stall", {62'd0, busy, stall}, 64'd0);
    read_hilo("reset", 32'h0, 32'h0);

    // MTHI / MTLO are single-cycle and set HI/LO for a later read
    rtype = 1'b1; funct = F_MTHI; src_a = 32'h12345678;
    #1;
    chk("mthi_nostall", {63'd0, stall}, 64'd0);
    tick();
    rtype = 1'b1; funct = F_MTLO; src_a = 32'h9ABCDEF0;
    tick();
    nop();
    #1;
    chk("mt_busy", {63'd0, busy}, 64'd0);
    read_hilo("mt", 32'h12345678, 32'h9ABCDEF0);

    // Combinational ALU table (HI is nonzero here, so row 10 proves rtype gating)
    for (int i = 0; i < 13; i++) begin
      ALUCtrl = vecs[i].ctrl;
      funct   = vecs[i].fn;
      rtype   = vecs[i].rt;
      src_a   = vecs[i].a;
      src_b   = vecs[i].b;
      #1;
      chk($sformatf("alu_vec%0d", i), {30'd0, result, zero, overflow},
          {30'd0, vecs[i].res, vecs[i].z, vecs[i].ov});
    end
    nop();

    // Multiply / divide results and latency
    issue(F_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done("mult_lat");
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    issue(F_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_done("multu_lat");
    read_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_lat");
    read_hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(F_DIVU, 32'd7, 32'd0);
    wait_done("divu0_lat");
    read_hilo("divu0", 32'h00000007, 32'hFFFFFFFF);

    issue(F_DIV, 32'hFFFFFFF9, 32'd0);
    wait_done("div0_lat");
    read_hilo("div0", 32'hFFFFFFF9, 32'hFFFFFFFF);

    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("divovf_lat");
    read_hilo("divovf", 32'h00000000, 32'h80000000);

    // Stall: ADD proceeds while busy; held MFLO stalls until the result lands
    issue(F_MULT, 32'd5, 32'd6);
    ALUCtrl = ALU_ADD; src_a = 32'd100; src_b = 32'd23;
    #1;
    chk("add_while_busy", {31'd0, result, stall}, {31'd0, 32'd123, 1'b0});
    tick();
    tick();
    tick();
    nop();
    rtype = 1'b1; funct = F_MFLO;
    #1;
    c = 0;
    while (stall && c < 100) begin
      c++;
      tick();
    end
    chk("mflo_stall_cycles", 64'(c), 64'd29);
    chk("mflo_after_stall", {32'd0, result}, {32'd0, 32'd30});
    nop();

    // Back-to-back: a held DIVU is re-accepted after one idle cycle
    rtype = 1'b1; funct = F_DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    wait_done("b2b_first");
    chk("b2b_gap", {62'd0, busy, stall}, 64'd0);
    tick();
    nop();
    #1;
    chk("b2b_reaccept", {63'd0, busy}, 64'd1);
    wait_done("b2b_second");
    read_hilo("b2b", 32'd2, 32'd14);

    // Reset mid-divide discards the operation and clears HI/LO
    issue(F_DIV, 32'd1000, 32'd3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rtype = 1'b1; funct = F_MFLO;
    #1;
    chk("rst_mid_busy_stall", {62'd0, busy, stall}, 64'd0);
    nop();
    read_hilo("rst_mid", 32'h0, 32'h0);
    issue(F_MULT, 32'd4, 32'd5);
    wait_done("post_rst_lat");
    read_hilo("post_rst", 32'h0, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
